// File: rtl/req_encoder_16to4.sv
// req_encoder_16to4: sticky 16-request pending register with a two-level priority
// encoder and a valid/ack handshake presenting the granted index.
module req_encoder_16to4 #(
  parameter int NREQ      = 16,
  parameter int CODE_W    = 4,
  parameter int PRIO_HIGH = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [NREQ-1:0]   req,
  input  logic              ack,
  output logic [CODE_W-1:0] code,
  output logic              valid,
  output logic [NREQ-1:0]   pending,
  output logic              any_pend
);
  typedef enum logic {IDLE, PRESENT} state_t;
  state_t state, state_next;
  logic [CODE_W-1:0] code_next, sel;
  logic [NREQ-1:0] clr_mask, pending_next;
  logic [3:0] grp_any;
  logic [1:0] grp_idx [4];
  logic [1:0] grp;

  function automatic logic [1:0] enc4(input logic [3:0] v);
    if (PRIO_HIGH != 0) return v[3] ? 2'd3 : v[2] ? 2'd2 : v[1] ? 2'd1 : 2'd0;
    return v[0] ? 2'd0 : v[1] ? 2'd1 : v[2] ? 2'd2 : 2'd3;
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_grp
    assign grp_any[g] = |pending[4*g +: 4];
    assign grp_idx[g] = enc4(pending[4*g +: 4]);
  end

  assign grp = enc4(grp_any);
  assign sel = {grp, grp_idx[grp]};
  assign valid = (state == PRESENT);
  // a fresh req on the bit being acked keeps it pending
  assign clr_mask = (valid & ack) ? (NREQ'(1) << code) : '0;
  assign pending_next = (pending & ~clr_mask) | req;

  always_comb begin
    state_next = state;
    code_next  = code;
    if (state == IDLE && en && (|pending)) begin
      state_next = PRESENT;
      code_next  = sel;
    end else if (state == PRESENT && ack) begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      code     <= '0;
      pending  <= '0;
      any_pend <= 1'b0;
    end else begin
      state    <= state_next;
      code     <= code_next;
      pending  <= pending_next;
      any_pend <= |pending_next;
    end
  end
endmodule

// File: tb/tb_req_encoder_16to4.sv
// tb_req_encoder_16to4: directed and randomized checks of both priority modes
// against a bit-scanning reference model.
module tb_req_encoder_16to4;
  logic clk = 0, rst_n = 0, en = 0, ack = 0;
  logic [15:0] req = '0;
  logic [3:0] code_h, code_l;
  logic valid_h, valid_l, any_h, any_l;
  logic [15:0] pend_h, pend_l;
  int total = 0, bad = 0;
  logic [15:0] mp [2];
  logic mv [2];
  logic [3:0] mc [2];

  always #5 clk = ~clk;

  req_encoder_16to4 #(.PRIO_HIGH(1)) u_high (.clk(clk), .rst_n(rst_n), .en(en), .req(req),
    .ack(ack), .code(code_h), .valid(valid_h), .pending(pend_h), .any_pend(any_h));
  req_encoder_16to4 #(.PRIO_HIGH(0)) u_low (.clk(clk), .rst_n(rst_n), .en(en), .req(req),
    .ack(ack), .code(code_l), .valid(valid_l), .pending(pend_l), .any_pend(any_l));

  function automatic logic [3:0] pick(input logic [15:0] p, input bit high);
    for (int n = 0; n < 16; n++) begin
      int b = high ? 15 - n : n;
      if (p[b]) return 4'(b);
    end
    return 4'd0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mp[i] = '0; mv[i] = 0; mc[i] = '0;
    end
  endtask

  // Advance model with the inputs present at the coming edge, then sample #1 after it.
  task automatic tick();
    logic [15:0] np [2];
    for (int i = 0; i < 2; i++) begin
      np[i] = (mp[i] & ~((mv[i] && ack) ? (16'd1 << mc[i]) : 16'd0)) | req;
      if (!mv[i]) begin
        if (en && mp[i] != 0) begin mv[i] = 1; mc[i] = pick(mp[i], i == 0); end
      end else if (ack) mv[i] = 0;
      mp[i] = np[i];
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 0; req = '0; en = 0; ack = 0; model_reset();
    @(posedge clk); #1;
    total++; if (valid_h !== 0 || pend_h !== 0 || code_h !== 0 || any_h !== 0) begin
      bad++; $display("FAIL reset_state: valid=%b pend=%h code=%h any=%b want 0", valid_h, pend_h, code_h, any_h); end
    rst_n = 1; en = 1;
    for (int k = 0; k < 5; k++) begin
      tick();
      total++; if (valid_h !== 0 || any_h !== 0 || code_h !== 0 || valid_l !== 0) begin
        bad++; $display("FAIL idle_quiet: valid=%b any=%b code=%h want 0", valid_h, any_h, code_h); end
    end
  endtask

  task automatic test_single();
    req = 16'h0400; tick(); req = '0;
    total++; if (pend_h !== 16'h0400 || any_h !== 1 || valid_h !== 0) begin
      bad++; $display("FAIL single_latch: pend=%h any=%b valid=%b want 0400 1 0", pend_h, any_h, valid_h); end
    tick();
    total++; if (valid_h !== 1 || code_h !== 4'hA || code_l !== 4'hA) begin
      bad++; $display("FAIL single_grant: valid=%b code_h=%h code_l=%h want 1 a a", valid_h, code_h, code_l); end
    ack = 1; tick(); ack = 0;
    total++; if (pend_h !== 0 || valid_h !== 0 || any_h !== 0) begin
      bad++; $display("FAIL single_ack: pend=%h valid=%b any=%b want 0 0 0", pend_h, valid_h, any_h); end
  endtask

  task automatic test_order();
    logic [3:0] exp_h [3] = '{4'hF, 4'h3, 4'h0};
    logic [3:0] exp_l [3] = '{4'h0, 4'h3, 4'hF};
    req = 16'h8009; tick(); req = '0;
    for (int k = 0; k < 3; k++) begin
      int n = 0;
      while (!valid_h && n < 5) begin tick(); n++; end
      total++; if (valid_h !== 1 || code_h !== exp_h[k] || code_l !== exp_l[k]) begin
        bad++; $display("FAIL order_%0d: valid=%b code_h=%h code_l=%h want 1 %h %h", k, valid_h, code_h, code_l, exp_h[k], exp_l[k]); end
      ack = 1; tick(); ack = 0;
    end
    tick(); tick();
    total++; if (valid_h !== 0 || valid_l !== 0 || pend_h !== 0 || pend_l !== 0) begin
      bad++; $display("FAIL order_drain: valid=%b/%b pend=%h/%h want 0", valid_h, valid_l, pend_h, pend_l); end
  endtask

  task automatic test_freeze();
    req = 16'h0008; tick(); req = '0; tick();
    total++; if (valid_h !== 1 || code_h !== 4'h3) begin
      bad++; $display("FAIL freeze_grant: valid=%b code=%h want 1 3", valid_h, code_h); end
    req = 16'h8000; tick(); req = '0; tick();
    total++; if (valid_h !== 1 || code_h !== 4'h3 || pend_h !== 16'h8008) begin
      bad++; $display("FAIL freeze_hold: valid=%b code=%h pend=%h want 1 3 8008", valid_h, code_h, pend_h); end
    ack = 1; req = 16'h0008; tick(); ack = 0; req = '0;
    total++; if (valid_h !== 0 || pend_h !== 16'h8008 || pend_l !== 16'h8008) begin
      bad++; $display("FAIL set_wins: valid=%b pend_h=%h pend_l=%h want 0 8008 8008", valid_h, pend_h, pend_l); end
    tick();
    total++; if (valid_h !== 1 || code_h !== 4'hF) begin
      bad++; $display("FAIL freeze_next: valid=%b code=%h want 1 f", valid_h, code_h); end
    ack = 1; tick(); ack = 0; tick();
    total++; if (valid_h !== 1 || code_h !== 4'h3) begin
      bad++; $display("FAIL regrant: valid=%b code=%h want 1 3", valid_h, code_h); end
    ack = 1; tick(); ack = 0;
    while (valid_l || pend_l != 0) begin ack = valid_l; tick(); end
    ack = 0;
  endtask

  task automatic test_enable();
    en = 0; req = 16'h0001; tick(); req = '0; tick();
    ack = 1; tick(); ack = 0;
    total++; if (valid_h !== 0 || pend_h !== 16'h0001) begin
      bad++; $display("FAIL en_block: valid=%b pend=%h want 0 0001", valid_h, pend_h); end
    en = 1; tick();
    total++; if (valid_h !== 1 || code_h !== 4'h0) begin
      bad++; $display("FAIL en_grant: valid=%b code=%h want 1 0", valid_h, code_h); end
    en = 0; tick(); tick();
    total++; if (valid_h !== 1 || code_h !== 4'h0) begin
      bad++; $display("FAIL en_hold: valid=%b code=%h want 1 0", valid_h, code_h); end
    ack = 1; tick(); ack = 0; en = 1;
    total++; if (valid_h !== 0 || pend_h !== 0) begin
      bad++; $display("FAIL en_ack: valid=%b pend=%h want 0 0", valid_h, pend_h); end
  endtask

  task automatic test_async_reset();
    req = 16'hFFFF; tick(); req = '0; tick();
    total++; if (valid_h !== 1 || pend_h !== 16'hFFFF) begin
      bad++; $display("FAIL prereset: valid=%b pend=%h want 1 ffff", valid_h, pend_h); end
    #2 rst_n = 0; model_reset(); #1;
    total++; if (valid_h !== 0 || pend_h !== 0 || any_h !== 0 || valid_l !== 0 || pend_l !== 0) begin
      bad++; $display("FAIL async_reset: valid=%b pend=%h any=%b want 0 0 0", valid_h, pend_h, any_h); end
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      req = 16'($urandom & $urandom & $urandom);
      en = ($urandom_range(0, 3) != 0);
      ack = $urandom_range(0, 1);
      tick();
      for (int i = 0; i < 2; i++) begin
        logic [15:0] p = i ? pend_l : pend_h;
        logic v = i ? valid_l : valid_h;
        logic [3:0] c = i ? code_l : code_h;
        logic a = i ? any_l : any_h;
        total++; if (p !== mp[i] || v !== mv[i] || c !== mc[i] || a !== (mp[i] != 0)) begin
          bad++; $display("FAIL random_%0d_%0d: pend=%h valid=%b code=%h any=%b want %h %b %h %b",
            k, i, p, v, c, a, mp[i], mv[i], mc[i], mp[i] != 0); end
      end
    end
    req = '0; ack = 0; en = 1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_order();
    test_freeze();
    test_enable();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
